pc_sequencer: RTL and testbench

//  Owns the program counter and drives instruction fetch. Consumes the next-PC

---
 rtl/pc_pkg.sv | 15 +
 rtl/next_pc_calc.sv | 35 +++
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// instruction word size and the default reset fetch address.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump beats taken branch beats sequential. All arithmetic
// wraps modulo 2^32; the branch offset is a signed word count.
module next_pc_calc
  import pc_pkg::*;
(
  input  logic [31:0] instr_pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_imm_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  output logic [31:0] next_pc_o,
  output logic        jmp_misaligned_o
);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;

  // The shift discards the two MSBs of the word offset, so the add wraps cleanly.
  assign seq_pc = instr_pc_i + 32'(WORD_BYTES);
  assign br_pc  = seq_pc + (br_imm_i << 2);

  // Priority mux; a jump target is forced to word alignment and flagged if it was not.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch can be inferred.
    next_pc_o        = seq_pc;
    jmp_misaligned_o = 1'b0;
    if (jmp_i) begin
      next_pc_o        = {jmp_target_i[31:2], 2'b00};
      jmp_misaligned_o = |jmp_target_i[1:0];
    end else if (br_taken_i) begin
      next_pc_o = br_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: keeps one instruction fetch outstanding, presents the
// returned word to decode and advances the PC only when decode consumes it.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_imm,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        addr_err
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] next_pc;
  logic        jmp_misaligned;

  next_pc_calc u_next_pc_calc (
    .instr_pc_i       (instr_pc_q),
    .br_taken_i       (br_taken),
    .br_imm_i         (br_imm),
    .jmp_i            (jmp),
    .jmp_target_i     (jmp_target),
    .next_pc_o        (next_pc),
    .jmp_misaligned_o (jmp_misaligned)
  );

  // State register; reset drops any in-flight response by returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Datapath registers: fetch PC, captured instruction and its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next-state and output decode. Redirect inputs only matter on the consume cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    imem_req      = 1'b0;
    imem_addr     = '0;
    addr_err      = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        if (imem_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = ST_OUT;
        end
      end
      ST_OUT: begin
        if (!stall) begin
          instr_valid_d = 1'b0;
          pc_d          = next_pc;
          addr_err      = jmp_misaligned;
          state_d       = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes hand-computed fetch
// addresses; a memory model checks each accepted request and a monitor checks
// each instruction presented to decode.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_instr_t;

  logic        clk, rst_n, stall, br_taken, jmp;
  logic [31:0] br_imm, jmp_target;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, addr_err;
  logic [31:0] instr, instr_pc;

  logic [31:0] exp_addr_q[$];
  exp_instr_t  exp_instr_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_delay = 0;
  int   rv_delay    = 1;
  logic check_period = 1'b0;
  logic stall_at_edge, ready_at_edge;

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_imm      (br_imm),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .addr_err    (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required end of test before it");
    $fatal(1, "simulation time limit reached");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [31:0] addr);
    exp_instr_t e;
    e.pc   = addr;
    e.word = mem_word(addr);
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req",    {31'b0, imem_req},    32'd0);
    check("rst_imem_addr",   imem_addr,            32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr",       instr,                32'd0);
    check("rst_instr_pc",    instr_pc,             32'd0);
    check("rst_addr_err",    {31'b0, addr_err},    32'd0);
  endtask

  // Wait for a presented instruction, optionally stall on it, then consume it
  // with the given redirect and set the memory timing for the following fetch.
  task automatic step(input int stall_n, input logic br, input logic [31:0] imm,
                      input logic j, input logic [31:0] tgt, input int rdy, input int rv,
                      input logic [31:0] exp_next, input logic exp_err);
    int t;
    t = 0;
    while (instr_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("instr_valid_wait", {31'b0, instr_valid}, 32'd1);
    for (int i = 0; i < stall_n; i++) begin
      stall    = 1'b1;
      br_taken = (i % 2 == 0);
      br_imm   = 32'h0000_0040;
      jmp      = 1'b0;
      @(negedge clk);
    end
    stall       = 1'b0;
    br_taken    = br;
    br_imm      = imm;
    jmp         = j;
    jmp_target  = tgt;
    ready_delay = rdy;
    rv_delay    = rv;
    push_fetch(exp_next);
    #1;
    check("addr_err_consume", {31'b0, addr_err}, {31'b0, exp_err});
    @(negedge clk);
    stall    = 1'b1;
    br_taken = 1'b0;
    jmp      = 1'b0;
    #1;
    check("addr_err_after",    {31'b0, addr_err},    32'd0);
    check("req_after_consume", {31'b0, imem_req},    32'd1);
    check("valid_dropped",     {31'b0, instr_valid}, 32'd0);
  endtask

  always @(posedge clk) begin
    stall_at_edge <= stall;
    ready_at_edge <= imem_ready;
  end

  // Memory model: accepts requests after ready_delay cycles, returns data
  // rv_delay cycles after acceptance, and checks each accepted address.
  initial begin : mem_model
    int          req_wait, rv_cnt;
    logic        pend;
    logic [31:0] pend_addr;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    req_wait = 0; rv_cnt = 0; pend = 1'b0; pend_addr = '0;
    forever begin
      @(negedge clk);
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) begin
        rv_cnt--;
        if (rv_cnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end
      end
      if (imem_req && !pend) begin
        if (req_wait >= ready_delay) begin
          imem_ready = 1'b1;
          pend       = 1'b1;
          pend_addr  = imem_addr;
          rv_cnt     = rv_delay;
          req_wait   = 0;
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_addr: got %h, expected no fetch at %0t", imem_addr, $time);
          end else begin
            check("fetch_addr", imem_addr, exp_addr_q.pop_front());
          end
        end else begin
          req_wait++;
        end
      end else begin
        req_wait = 0;
      end
      check("no_ready_with_rvalid", {31'b0, imem_ready & imem_rvalid}, 32'd0);
    end
  end

  // Request monitor: an unaccepted request must hold its address; addresses are aligned.
  initial begin : req_monitor
    logic        prev_req;
    logic [31:0] prev_addr;
    prev_req = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_req && !ready_at_edge) begin
        check("req_hold",  {31'b0, imem_req}, 32'd1);
        check("addr_hold", imem_addr, prev_addr);
      end
      if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      prev_req  = imem_req;
      prev_addr = imem_addr;
    end
  end

  // Instruction monitor: pops the scoreboard on each new presentation, checks
  // the outputs stay frozen under stall and drop after a consume.
  initial begin : instr_monitor
    logic        prev_valid;
    logic [31:0] prev_instr, prev_pc;
    int          cyc, last_rise;
    exp_instr_t  e;
    prev_valid = 1'b0; prev_instr = '0; prev_pc = '0; cyc = 0; last_rise = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_valid = 1'b0;
        last_rise  = -1;
      end else begin
        if (prev_valid) begin
          if (stall_at_edge) begin
            check("stall_valid_held", {31'b0, instr_valid}, 32'd1);
            check("stall_instr_held", instr, prev_instr);
            check("stall_pc_held",    instr_pc, prev_pc);
            check("stall_no_req",     {31'b0, imem_req}, 32'd0);
          end else begin
            check("consume_clears_valid", {31'b0, instr_valid}, 32'd0);
          end
        end else if (instr_valid) begin
          if (exp_instr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL instr_present: got pc %h, expected no instruction at %0t", instr_pc, $time);
          end else begin
            e = exp_instr_q.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr",    instr,    e.word);
          end
          if (check_period && last_rise >= 0) check("valid_period", cyc - last_rise, 32'd3);
          last_rise = cyc;
        end
        prev_valid = instr_valid;
        prev_instr = instr;
        prev_pc    = instr_pc;
      end
    end
  end

  initial begin : driver
    int t;
    rst_n = 1'b0; stall = 1'b1; br_taken = 1'b0; jmp = 1'b0;
    br_imm = '0; jmp_target = '0;
    ready_delay = 0; rv_delay = 1; check_period = 1'b1;
    push_fetch(RESET_PC);
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // 1: sequential fetch with single-cycle memory, one instruction every 3 cycles
    step(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1, 32'h0000_0004, 1'b0);
    step(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1, 32'h0000_0008, 1'b0);
    step(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1, 32'h0000_000C, 1'b0);
    step(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1, 32'h0000_0010, 1'b0);
    // 2: backward branch, then forward branch from 0x10
    step(0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 0, 1, 32'h0000_000C, 1'b0);
    step(0, 1'b0, 32'h0,         1'b0, 32'h0, 0, 1, 32'h0000_0010, 1'b0);
    step(0, 1'b1, 32'h0000_0003, 1'b0, 32'h0, 0, 1, 32'h0000_0020, 1'b0);
    // 3: jump and branch together, misaligned target
    step(0, 1'b1, 32'h0000_0005, 1'b1, 32'h0000_0103, 0, 1, 32'h0000_0100, 1'b1);
    check_period = 1'b0;
    // 4: five-cycle stall with br_taken toggling; next fetch slowed for case 5
    step(5, 1'b0, 32'h0, 1'b0, 32'h0, 4, 3, 32'h0000_0104, 1'b0);
    // 5: slow fetch of 0x104 is checked by the monitors; restore fast memory
    step(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1, 32'h0000_0108, 1'b0);
    // 6: reset while the 0x10C fetch is in RESP; its response lands in IDLE
    step(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 2, 32'h0000_010C, 1'b0);
    @(negedge clk);
    check("in_resp_before_reset", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_addr_q.delete();
    exp_instr_q.delete();
    push_fetch(RESET_PC);
    rv_delay = 1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_after_reset", {31'b0, imem_req}, 32'd0);
    step(0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 1'b0);
    step(0, 1'b0, 32'h0, 1'b0, 32'h0,         0, 1, 32'h0000_0000, 1'b0);
    step(0, 1'b0, 32'h0, 1'b0, 32'h0,         0, 1, 32'h0000_0004, 1'b0);

    t = 0;
    while (instr_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("final_valid_wait", {31'b0, instr_valid}, 32'd1);
    repeat (3) @(negedge clk);
    check("addr_queue_empty",  exp_addr_q.size(),  32'd0);
    check("instr_queue_empty", exp_instr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
